// File: rtl/cfg_chain_loader.sv
// rtl/cfg_chain_loader.sv - serializes bitstream words LSB-first into a CCFF scan chain
module cfg_chain_loader #(
  parameter int DATA_W    = 32,
  parameter int CHAIN_LEN = 2048,
  parameter int CNT_W     = 16
) (
  input  logic              prog_clk,
  input  logic              pReset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  bit_count
);

  localparam int WL_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CHAIN_LEN_C = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] DATA_W_C    = CNT_W'(DATA_W);

  typedef enum logic [1:0] {IDLE, FETCH, SHIFT, DONE} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] shreg;
  logic [WL_W-1:0]   word_left;
  logic [CNT_W-1:0]  remaining;
  logic [WL_W-1:0]   take;
  logic              last_bit;

  // The final word may be partial: only the bits still missing from the chain are shifted.
  assign remaining = CHAIN_LEN_C - bit_count;
  assign take      = (remaining < DATA_W_C) ? WL_W'(remaining) : WL_W'(DATA_W);
  assign last_bit  = (bit_count + CNT_W'(1)) == CHAIN_LEN_C;

  always_comb begin
    state_nxt     = state;
    cfg_ready     = 1'b0;
    ccff_shift_en = (state == SHIFT);
    ccff_head     = (state == SHIFT) && shreg[0];
    busy          = (state == FETCH) || (state == SHIFT);
    done          = (state == DONE);
    case (state)
      IDLE, DONE: begin
        if (start) state_nxt = FETCH;
      end
      FETCH: begin
        cfg_ready = !abort;
        if (cfg_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        if (word_left == WL_W'(1)) state_nxt = last_bit ? DONE : FETCH;
      end
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  always_ff @(posedge prog_clk) begin
    if (!pReset_n) begin
      state     <= IDLE;
      shreg     <= '0;
      word_left <= '0;
      bit_count <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE, DONE: begin
          if (start && !abort) bit_count <= '0;
        end
        FETCH: begin
          if (cfg_valid && cfg_ready) begin
            shreg     <= cfg_data;
            word_left <= take;
          end
        end
        // The bit on ccff_head this cycle is committed to the chain even if abort is seen.
        SHIFT: begin
          shreg     <= shreg >> 1;
          bit_count <= bit_count + CNT_W'(1);
          word_left <= word_left - WL_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cfg_chain_loader.sv
// tb/tb_cfg_chain_loader.sv - self-checking bench for cfg_chain_loader
module tb_cfg_chain_loader;

  logic prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  logic        pReset_n, start, abort, cfg_valid, sel;
  logic [31:0] cfg_data;

  logic        rdy_a, head_a, sh_a, busy_a, done_a;
  logic [15:0] bc_a;
  logic        rdy_b, head_b, sh_b, busy_b, done_b;
  logic [15:0] bc_b;

  cfg_chain_loader #(.DATA_W(32), .CHAIN_LEN(64), .CNT_W(16)) u_a (
    .prog_clk(prog_clk), .pReset_n(pReset_n),
    .start(start & ~sel), .abort(abort & ~sel),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid & ~sel),
    .cfg_ready(rdy_a), .ccff_head(head_a), .ccff_shift_en(sh_a),
    .busy(busy_a), .done(done_a), .bit_count(bc_a)
  );

  cfg_chain_loader #(.DATA_W(32), .CHAIN_LEN(40), .CNT_W(16)) u_b (
    .prog_clk(prog_clk), .pReset_n(pReset_n),
    .start(start & sel), .abort(abort & sel),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid & sel),
    .cfg_ready(rdy_b), .ccff_head(head_b), .ccff_shift_en(sh_b),
    .busy(busy_b), .done(done_b), .bit_count(bc_b)
  );

  logic        cfg_ready, ccff_head, ccff_shift_en, busy, done;
  logic [15:0] bit_count;
  assign cfg_ready     = sel ? rdy_b  : rdy_a;
  assign ccff_head     = sel ? head_b : head_a;
  assign ccff_shift_en = sel ? sh_b   : sh_a;
  assign busy          = sel ? busy_b : busy_a;
  assign done          = sel ? done_b : done_a;
  assign bit_count     = sel ? bc_b   : bc_a;

  int tests = 0;
  int fails = 0;

  logic [31:0] words[$];
  int          gaps[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Runs one complete load on the selected instance and checks it against a
  // cycle-level model built from words/gaps: word k handshakes after gaps[k]
  // idle FETCH cycles, then shifts min(32, remaining) bits LSB-first.
  task automatic run_load(input string tag, input int start_at, input int exp_done, input int exp_bc);
    int chain_len, nw, c, len, widx, gap_left, cyc, done_cyc, bad, post_bad, err;
    logic exp_bits[$];
    logic got_bits[$];
    int   exp_hs[$], got_hs[$], exp_sh[$], got_sh[$];
    chain_len = sel ? 40 : 64;
    nw = (chain_len + 31) / 32;
    c = 1;
    for (int k = 0; k < nw; k++) begin
      len = (chain_len - 32 * k < 32) ? chain_len - 32 * k : 32;
      c += gaps[k];
      exp_hs.push_back(c);
      for (int j = 0; j < len; j++) begin
        exp_sh.push_back(c + 1 + j);
        exp_bits.push_back(words[k][j]);
      end
      c += 1 + len;
    end

    @(negedge prog_clk);
    start = 1'b1; cfg_valid = 1'b0; cfg_data = $urandom;
    @(negedge prog_clk);
    start = 1'b0;
    cyc = 1; widx = 0; gap_left = gaps[0]; done_cyc = -1; bad = 0;
    #1;
    check({tag, " cycle1_bit_count"}, 64'(bit_count), 64'd0);
    check({tag, " cycle1_done_busy"}, {62'd0, done, busy}, 64'b01);
    while (cyc < 400) begin
      start = (cyc == start_at);
      if (cfg_ready) begin
        cfg_data = (widx < words.size()) ? words[widx] : $urandom;
        if (gap_left > 0) begin
          cfg_valid = 1'b0;
          gap_left--;
        end else begin
          cfg_valid = 1'b1;
        end
      end else begin
        cfg_valid = 1'($urandom_range(0, 1));
        cfg_data  = $urandom;
      end
      #1;
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (bit_count !== 16'(got_sh.size())) bad++;
      if (!busy) bad++;
      if (cfg_ready && cfg_valid) begin
        got_hs.push_back(cyc);
        widx++;
        if (widx < gaps.size()) gap_left = gaps[widx];
      end
      if (ccff_shift_en) begin
        got_sh.push_back(cyc);
        got_bits.push_back(ccff_head);
      end else if (ccff_head) begin
        bad++;
      end
      @(negedge prog_clk);
      cyc++;
    end
    start = 1'b0;

    check({tag, " done_cycle"}, 64'(done_cyc), 64'(c));
    if (exp_done >= 0) check({tag, " done_cycle_vec"}, 64'(done_cyc), 64'(exp_done));
    check({tag, " bit_count"}, 64'(bit_count), 64'(exp_bc));
    check({tag, " per_cycle_violations"}, 64'(bad), 64'd0);
    check({tag, " handshakes"}, 64'(got_hs.size()), 64'(exp_hs.size()));
    err = 0;
    for (int i = 0; i < got_hs.size() && i < exp_hs.size(); i++) if (got_hs[i] != exp_hs[i]) err++;
    check({tag, " handshake_cycle_errors"}, 64'(err), 64'd0);
    check({tag, " shift_cycles"}, 64'(got_sh.size()), 64'(chain_len));
    err = 0;
    for (int i = 0; i < got_sh.size() && i < exp_sh.size(); i++) if (got_sh[i] != exp_sh[i]) err++;
    for (int i = 0; i < got_bits.size() && i < exp_bits.size(); i++) if (got_bits[i] !== exp_bits[i]) err++;
    check({tag, " stream_errors"}, 64'(err), 64'd0);

    post_bad = 0;
    repeat (3) begin
      @(negedge prog_clk);
      cfg_valid = 1'b1;
      #1;
      if (cfg_ready || ccff_shift_en || ccff_head || busy || !done) post_bad++;
    end
    cfg_valid = 1'b0;
    check({tag, " after_done"}, 64'(post_bad), 64'd0);
  endtask

  typedef struct {
    bit          sel;
    int          gap0;
    int          gap1;
    int          start_at;
    logic [31:0] w0;
    logic [31:0] w1;
    int          exp_done;
    int          exp_bc;
  } vec_t;

  vec_t tbl[5];

  initial begin
    tbl[0] = '{1'b0, 0, 0, -1, 32'hA5A5_0F0F, 32'h1234_5678, 67, 64};
    tbl[1] = '{1'b1, 0, 0, -1, 32'hFFFF_FFFF, 32'h0000_00FF, 43, 40};
    tbl[2] = '{1'b0, 0, 10, -1, 32'hDEAD_BEEF, 32'h0F1E_2D3C, 77, 64};
    tbl[3] = '{1'b1, 10, 0, -1, 32'h8000_0001, 32'h0000_005A, 53, 40};
    tbl[4] = '{1'b0, 0, 0, 20, 32'h3C3C_C3C3, 32'hF00D_CAFE, 67, 64};

    pReset_n = 1'b0; start = 1'b1; abort = 1'b0; cfg_valid = 1'b1;
    cfg_data = 32'hFFFF_FFFF; sel = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge prog_clk);
      #1;
      check($sformatf("reset_outputs_%0d", i),
            {12'd0, rdy_a, head_a, sh_a, busy_a, done_a, bc_a, rdy_b, head_b, sh_b, busy_b, done_b, bc_b},
            64'd0);
    end
    @(negedge prog_clk);
    pReset_n = 1'b1; start = 1'b0; cfg_valid = 1'b0;

    for (int i = 0; i < 5; i++) begin
      sel = tbl[i].sel;
      words = '{tbl[i].w0, tbl[i].w1};
      gaps  = '{tbl[i].gap0, tbl[i].gap1};
      run_load($sformatf("vec%0d", i), tbl[i].start_at, tbl[i].exp_done, tbl[i].exp_bc);
    end

    // Abort in the 5th SHIFT cycle (cycle 6), then a clean reload from zero.
    sel = 1'b0;
    @(negedge prog_clk);
    start = 1'b1;
    @(negedge prog_clk);
    start = 1'b0; cfg_valid = 1'b1; cfg_data = 32'h0000_FFFF;
    repeat (5) @(negedge prog_clk);
    cfg_valid = 1'b0; abort = 1'b1;
    #1;
    check("abort_cycle_shift_en", 64'(ccff_shift_en), 64'd1);
    @(negedge prog_clk);
    abort = 1'b0;
    #1;
    check("abort_next_outputs", {60'd0, ccff_shift_en, busy, done, ccff_head}, 64'd0);
    check("abort_bit_count", 64'(bit_count), 64'd5);
    @(negedge prog_clk);
    #1;
    check("abort_bit_count_hold", 64'(bit_count), 64'd5);
    words = '{32'h0BAD_F00D, 32'h7777_1111};
    gaps  = '{0, 3};
    run_load("reload_after_abort", -1, 70, 64);

    // Abort while a word is offered in FETCH: the word must not be accepted.
    @(negedge prog_clk);
    start = 1'b1;
    @(negedge prog_clk);
    start = 1'b0; abort = 1'b1; cfg_valid = 1'b1; cfg_data = 32'hFFFF_FFFF;
    #1;
    check("abort_fetch_ready", 64'(cfg_ready), 64'd0);
    @(negedge prog_clk);
    abort = 1'b0; cfg_valid = 1'b0;
    #1;
    check("abort_fetch_after", {61'd0, busy, ccff_shift_en, done}, 64'd0);
    check("abort_fetch_bit_count", 64'(bit_count), 64'd0);

    // start and abort together: abort wins.
    start = 1'b1; abort = 1'b1;
    @(negedge prog_clk);
    start = 1'b0; abort = 1'b0;
    #1;
    check("start_abort_same_cycle", 64'(busy), 64'd0);

    // Reset in the middle of a load.
    @(negedge prog_clk);
    start = 1'b1;
    @(negedge prog_clk);
    start = 1'b0; cfg_valid = 1'b1; cfg_data = 32'hFFFF_FFFF;
    repeat (8) @(negedge prog_clk);
    pReset_n = 1'b0;
    @(negedge prog_clk);
    #1;
    check("midload_reset", {58'd0, cfg_ready, ccff_head, ccff_shift_en, busy, done, |bit_count}, 64'd0);
    pReset_n = 1'b1; cfg_valid = 1'b0;

    for (int r = 0; r < 20; r++) begin
      sel   = 1'($urandom_range(0, 1));
      words = '{$urandom, $urandom};
      gaps  = '{$urandom_range(0, 3), $urandom_range(0, 3)};
      run_load($sformatf("rand%0d", r),
               ($urandom_range(0, 1) != 0) ? int'($urandom_range(2, 30)) : -1,
               -1, sel ? 40 : 64);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
